mac_array: RTL and testbench

MAC_ARRAY -- requirements
Module: mac_array

---
 rtl/nn_pkg.sv | 29 ++
 rtl/mac_lane.sv | 91 +++++++++
 rtl/mac_array.sv | 124 ++++++++++++
 tb/tb_mac_array.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// Shared definitions for the neural-network datapath blocks.
// Latency: n/a (types, constants and elaboration helpers only).
// Backpressure: n/a.
//
// Holds the MAC controller state encoding and the default operand and
// accumulator widths used by mac_array and mac_lane.

package nn_pkg;

    // Default signed operand width (weights, inputs, bias).
    localparam int DEF_DATA_W = 16;
    // Default signed accumulator / result width; must be >= 2*DEF_DATA_W.
    localparam int DEF_ACC_W  = 32;

    // Controller states.  busy is high in every state except ST_IDLE.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_BIAS  = 2'd2,
        ST_OUT   = 2'd3
    } state_e;

    // Width of an index counter covering 0..n-1.  It never returns zero, so
    // a one-element vector still gets a real (one-bit) counter register.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mac_lane.sv
// One output channel: signed multiply-accumulate plus bias add into a result register.
// Latency: acc updates the cycle after acc_en; res updates the cycle after res_en.
// Backpressure: none; the controller only pulses clr/acc_en/res_en when allowed.
//
// Ports:
//   clk, rstn    clock, asynchronous active-low reset
//   clr          clear accumulator and capture bias (start accepted)
//   acc_en       accept one element pair: acc += sext(w * x)
//   res_en       write res = acc + sext(bias) (clamped at zero with ReLU)
//   x, w, bias   signed DATA_W operands
//   res          signed ACC_W result, held until the next res_en
//
// Optional feature: define MAC_ARRAY_RELU_EN to clamp negative results to 0.

module mac_lane
    import nn_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ACC_W  = DEF_ACC_W
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     clr,
    input  logic                     acc_en,
    input  logic                     res_en,
    input  logic signed [DATA_W-1:0] x,
    input  logic signed [DATA_W-1:0] w,
    input  logic signed [DATA_W-1:0] bias,
    output logic        [ACC_W-1:0]  res
);

    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    prod_ext;
    logic signed [ACC_W-1:0]    bias_ext;
    logic signed [ACC_W-1:0]    sum;

    logic signed [ACC_W-1:0]    acc_q, acc_d;
    logic signed [DATA_W-1:0]   bias_q;
    logic signed [ACC_W-1:0]    res_q, res_d;

    // Both operands are signed, so the product is computed at full
    // 2*DATA_W width and the size casts sign-extend to ACC_W.
    assign prod     = w * x;
    assign prod_ext = ACC_W'(prod);
    assign bias_ext = ACC_W'(bias_q);

    // Plain two's-complement addition: overflow wraps modulo 2^ACC_W.
    assign sum = acc_q + bias_ext;

    always_comb begin
        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (acc_en) begin
            acc_d = acc_q + prod_ext;
        end
    end

`ifdef MAC_ARRAY_RELU_EN
    // ReLU acts on the wrapped sum, so its sign bit decides the clamp.
    always_comb begin
        res_d = sum;
        if (sum[ACC_W-1]) begin
            res_d = '0;
        end
    end
`else
    always_comb begin
        res_d = sum;
    end
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            acc_q  <= '0;
            bias_q <= '0;
            res_q  <= '0;
        end else begin
            acc_q <= acc_d;
            if (clr) begin
                bias_q <= bias;
            end
            if (res_en) begin
                res_q <= res_d;
            end
        end
    end

    assign res = res_q;

endmodule

// File: rtl/mac_array.sv
// NUM_CH parallel dot-product neurons sharing one input stream, with per-channel bias.
// Latency: out_valid rises in the second cycle after the last input handshake.
// Backpressure: in_ready only in ACCUM; results held stable in OUT until out_ready.
//
// Ports:
//   clk, rstn             clock, asynchronous active-low reset
//   start                 one-cycle request; honoured only in IDLE, latches bias
//   bias[NUM_CH*DATA_W]   per-channel signed bias, channel i at [i*DATA_W +: DATA_W]
//   in_valid/in_ready     element-pair handshake
//   in_x[DATA_W]          signed input element shared by all channels
//   in_w[NUM_CH*DATA_W]   per-channel signed weights, packed like bias
//   out_valid/out_ready   result handshake
//   out_data[NUM_CH*ACC_W] per-channel signed results, channel i at [i*ACC_W +: ACC_W]
//   busy                  high whenever the controller is not idle
//
// Optional feature: define MAC_ARRAY_RELU_EN to clamp each result at zero.
// ACC_W must be at least 2*DATA_W so a full product fits the accumulator.

module mac_array
    import nn_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ACC_W   = DEF_ACC_W,
    parameter int VEC_LEN = 8,
    parameter int NUM_CH  = 4
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       start,
    input  logic [NUM_CH*DATA_W-1:0]   bias,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic signed [DATA_W-1:0]   in_x,
    input  logic [NUM_CH*DATA_W-1:0]   in_w,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [NUM_CH*ACC_W-1:0]    out_data,
    output logic                       busy
);

    localparam int             CNT_W    = cnt_width(VEC_LEN);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(VEC_LEN - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic start_acc;   // start honoured (IDLE only)
    logic pair_acc;    // element pair accepted this cycle
    logic res_wr;      // lanes write their biased result

    assign start_acc = (state_q == ST_IDLE) && start;
    assign pair_acc  = (state_q == ST_ACCUM) && in_valid;
    assign res_wr    = (state_q == ST_BIAS);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_ACCUM;
                    cnt_d   = '0;
                end
            end
            ST_ACCUM: begin
                // Gaps in in_valid simply hold the counter.
                if (in_valid) begin
                    if (cnt_q == LAST_IDX) begin
                        state_d = ST_BIAS;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_BIAS: begin
                state_d = ST_OUT;
            end
            ST_OUT: begin
                // A start seen alongside the output handshake is dropped:
                // only IDLE looks at start.
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // All handshake outputs decode the registered state, so reset forces
    // them low immediately and they are glitch-free relative to clk.
    assign in_ready  = (state_q == ST_ACCUM);
    assign out_valid = (state_q == ST_OUT);
    assign busy      = (state_q != ST_IDLE);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
        mac_lane #(
            .DATA_W (DATA_W),
            .ACC_W  (ACC_W)
        ) u_lane (
            .clk    (clk),
            .rstn   (rstn),
            .clr    (start_acc),
            .acc_en (pair_acc),
            .res_en (res_wr),
            .x      (in_x),
            .w      (in_w[g*DATA_W +: DATA_W]),
            .bias   (bias[g*DATA_W +: DATA_W]),
            .res    (out_data[g*ACC_W +: ACC_W])
        );
    end

endmodule

// File: tb/tb_mac_array.sv
// Self-checking bench for mac_array: directed cases plus randomized dot products.
// Latency: checks out_valid exactly two cycles after the last input handshake.
// Backpressure: exercises in_valid gaps and out_ready stalls.
//
// The reference model computes each channel as a plain 64-bit dot product plus
// bias, then wraps to ACC_W (and clamps at zero when MAC_ARRAY_RELU_EN is set).

module tb_mac_array;

    localparam int DATA_W  = 16;
    localparam int ACC_W   = 32;
    localparam int VEC_LEN = 8;
    localparam int NUM_CH  = 4;

    logic                      clk;
    logic                      rstn;
    logic                      start;
    logic [NUM_CH*DATA_W-1:0]  bias;
    logic                      in_valid;
    logic                      in_ready;
    logic signed [DATA_W-1:0]  in_x;
    logic [NUM_CH*DATA_W-1:0]  in_w;
    logic                      out_valid;
    logic                      out_ready;
    logic [NUM_CH*ACC_W-1:0]   out_data;
    logic                      busy;

    mac_array #(
        .DATA_W  (DATA_W),
        .ACC_W   (ACC_W),
        .VEC_LEN (VEC_LEN),
        .NUM_CH  (NUM_CH)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start),
        .bias      (bias),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_w      (in_w),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int xs [VEC_LEN];
    int ws [NUM_CH][VEC_LEN];
    int bs [NUM_CH];

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: sum over the vector in wide arithmetic, then wrap.
    function automatic logic signed [ACC_W-1:0] model(input int ch);
        longint                  s;
        logic signed [ACC_W-1:0] r;
        s = longint'(bs[ch]);
        for (int k = 0; k < VEC_LEN; k++) begin
            s += longint'(ws[ch][k]) * longint'(xs[k]);
        end
        r = ACC_W'(s);
`ifdef MAC_ARRAY_RELU_EN
        if (r < 0) r = '0;
`endif
        return r;
    endfunction

    function automatic logic signed [ACC_W-1:0] lane_out(input int ch);
        return $signed(out_data[ch*ACC_W +: ACC_W]);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input int w, input int x0, input int xstep, input int b);
        for (int k = 0; k < VEC_LEN; k++) begin
            xs[k] = x0 + k * xstep;
            for (int ch = 0; ch < NUM_CH; ch++) ws[ch][k] = w;
        end
        for (int ch = 0; ch < NUM_CH; ch++) bs[ch] = b;
    endtask

    task automatic fill_random();
        logic signed [DATA_W-1:0] t;
        for (int k = 0; k < VEC_LEN; k++) begin
            t = DATA_W'($urandom);
            xs[k] = t;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                t = DATA_W'($urandom);
                ws[ch][k] = t;
            end
        end
        for (int ch = 0; ch < NUM_CH; ch++) begin
            t = DATA_W'($urandom);
            bs[ch] = t;
        end
    endtask

    task automatic drive_pair(input int k);
        in_valid = 1'b1;
        in_x     = DATA_W'(xs[k]);
        for (int ch = 0; ch < NUM_CH; ch++) begin
            in_w[ch*DATA_W +: DATA_W] = DATA_W'(ws[ch][k]);
        end
    endtask

    task automatic load_bias();
        for (int ch = 0; ch < NUM_CH; ch++) begin
            bias[ch*DATA_W +: DATA_W] = DATA_W'(bs[ch]);
        end
    endtask

    // gap_mode: 0 = back-to-back, 1 = idle cycle between pairs, 2 = random gaps.
    // stall: cycles out_ready is held low once results are valid.
    // poke: pulse start mid-accumulation, during the stall and on the handshake.
    task automatic run(input string tag, input int gap_mode, input int stall, input bit poke);
        load_bias();
        out_ready = (stall == 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        // Bias must be latched at start: scramble the port afterwards.
        bias = '1;
        check({tag, "/busy_accum"}, busy, 1);
        for (int k = 0; k < VEC_LEN; k++) begin
            if ((gap_mode == 1 && k > 0) || (gap_mode == 2 && $urandom_range(1, 0) == 1)) begin
                in_valid = 1'b0;
                in_x     = DATA_W'($urandom);
                in_w     = {NUM_CH{DATA_W'($urandom)}};
                tick();
            end
            drive_pair(k);
            if (poke && k == 3) start = 1'b1;
            check($sformatf("%s/in_ready_%0d", tag, k), in_ready, 1);
            tick();
            start = 1'b0;
        end
        in_valid = 1'b0;
        check({tag, "/in_ready_bias"}, in_ready, 0);
        check({tag, "/out_valid_bias"}, out_valid, 0);
        tick();
        check({tag, "/out_valid_rise"}, out_valid, 1);
        for (int ch = 0; ch < NUM_CH; ch++) begin
            check($sformatf("%s/data_ch%0d", tag, ch), lane_out(ch), model(ch));
        end
        for (int i = 0; i < stall; i++) begin
            if (poke) start = 1'b1;
            tick();
            start = 1'b0;
            check($sformatf("%s/stall_valid_%0d", tag, i), out_valid, 1);
            for (int ch = 0; ch < NUM_CH; ch++) begin
                check($sformatf("%s/stall_ch%0d_%0d", tag, ch, i), lane_out(ch), model(ch));
            end
        end
        out_ready = 1'b1;
        start     = poke;
        tick();
        start = 1'b0;
        check({tag, "/out_valid_drop"}, out_valid, 0);
        check({tag, "/busy_after"}, busy, 0);
        tick();
        check({tag, "/idle_stays"}, busy, 0);
    endtask

    initial begin
        logic signed [ACC_W-1:0] exp33;

        rstn      = 1'b0;
        start     = 1'b0;
        bias      = '0;
        in_valid  = 1'b0;
        in_x      = '0;
        in_w      = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset/in_ready", in_ready, 0);
        check("reset/out_valid", out_valid, 0);
        check("reset/busy", busy, 0);
        for (int ch = 0; ch < NUM_CH; ch++) begin
            check($sformatf("reset/data_ch%0d", ch), lane_out(ch), 0);
        end
        #2 rstn = 1'b1;
        tick();

        // Weights 2, x = 1..8, bias 5 -> 2*36 + 5 = 77.
        fill(2, 1, 1, 5);
        run("basic", 0, 0, 1'b0);
        for (int ch = 0; ch < NUM_CH; ch++) begin
            check($sformatf("basic/const_ch%0d", ch), lane_out(ch), 77);
        end

        // Weights -3, x = 4, bias -10 -> -96 - 10 = -106 (0 with ReLU).
        fill(-3, 4, 0, -10);
        run("negative", 0, 0, 1'b0);
`ifdef MAC_ARRAY_RELU_EN
        exp33 = '0;
`else
        exp33 = -106;
`endif
        for (int ch = 0; ch < NUM_CH; ch++) begin
            check($sformatf("negative/const_ch%0d", ch), lane_out(ch), exp33);
        end

        // Alternating in_valid, 5-cycle output stall, start pokes ignored.
        fill(2, 1, 1, 5);
        run("stall", 1, 5, 1'b1);
        for (int ch = 0; ch < NUM_CH; ch++) begin
            check($sformatf("stall/const_ch%0d", ch), lane_out(ch), 77);
        end

        // 8 * 32767^2 = 8589410312 wraps mod 2^32 to -524280.
        fill(32767, 32767, 0, 0);
        run("wrap", 0, 0, 1'b0);
        for (int ch = 0; ch < NUM_CH; ch++) begin
            check($sformatf("wrap/const_ch%0d", ch), lane_out(ch), -524280);
        end

        // Abandon a sequence after element 4 with an asynchronous reset.
        fill(2, 1, 1, 5);
        load_bias();
        out_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            drive_pair(k);
            tick();
        end
        drive_pair(5);
        #2 rstn = 1'b0;
        #1;
        check("midrst/in_ready", in_ready, 0);
        check("midrst/out_valid", out_valid, 0);
        check("midrst/busy", busy, 0);
        for (int ch = 0; ch < NUM_CH; ch++) begin
            check($sformatf("midrst/data_ch%0d", ch), lane_out(ch), 0);
        end
        #2 rstn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("midrst/no_valid_%0d", i), out_valid, 0);
            check($sformatf("midrst/idle_%0d", i), busy, 0);
        end
        in_valid = 1'b0;
        run("recover", 0, 0, 1'b0);
        for (int ch = 0; ch < NUM_CH; ch++) begin
            check($sformatf("recover/const_ch%0d", ch), lane_out(ch), 77);
        end

        // Randomized operands, gaps, stalls and stray starts.
        for (int r = 0; r < 8; r++) begin
            fill_random();
            run($sformatf("rand%0d", r), 2, $urandom_range(3, 0), 1'($urandom_range(1, 0)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Watchdog: the directed sequence is bounded, so this should never fire.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, observed hang expected completion");
        $fatal(1, "timeout");
    end

endmodule
